// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum and the word size in bytes.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit RAM: synchronous write, combinational read.
// Ports: clk, we, addr (word index), wdata, rdata. Contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request in IDLE, inserts WAIT_CYCLES
// wait states, then strobes a one-cycle response.
// Ports: clk, reset (sync, active-high); req_valid/req_we/req_addr/req_wdata
// from the initiator; req_ready, rsp_valid, rsp_rdata, rsp_err, busy back.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t          state;
    logic [3:0]      cnt;
    logic            lat_we;
    logic            lat_mis;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;

    logic            req_mis;
    logic [AW-1:0]   req_idx;
    logic            cur_we;
    logic            cur_mis;
    logic [AW-1:0]   cur_idx;
    logic            go_resp;
    logic            arr_we;
    logic [31:0]     arr_rdata;
    logic            unused_hi;

    assign req_mis   = (req_addr[1:0] != 2'b00);
    assign req_idx   = req_addr[AW+1:2];
    assign unused_hi = ^req_addr[31:AW+2];

    // With zero wait states the response is formed at the accept edge,
    // before the latches hold the request, so look at the live inputs.
    always_comb begin
        cur_we  = lat_we;
        cur_mis = lat_mis;
        cur_idx = lat_idx;
        if (state == IDLE) begin
            cur_we  = req_we;
            cur_mis = req_mis;
            cur_idx = req_idx;
        end
    end

    always_comb begin
        go_resp = 1'b0;
        if (state == IDLE && req_valid && WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
        end
        if (state == WAIT && cnt == 4'd0) begin
            go_resp = 1'b1;
        end
    end

    // Commit happens on the edge that ends RESP; a reset on that edge aborts it.
    assign arr_we = (state == RESP) && lat_we && !lat_mis && !reset;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (cur_idx),
        .wdata(lat_wdata),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_mis   <= req_mis;
                        lat_idx   <= req_idx;
                        lat_wdata <= req_wdata;
                        if (WAIT_CYCLES != 0) begin
                            state     <= WAIT;
                            cnt       <= CNT_LOAD;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (go_resp) begin
                state     <= RESP;
                req_ready <= 1'b0;
                busy      <= 1'b1;
                rsp_valid <= 1'b1;
                rsp_err   <= cur_mis;
                if (!cur_we) begin
                    rsp_rdata <= cur_mis ? 32'd0 : arr_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states,
// one with 0 wait states, both 256 words deep.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid[0]),
        .req_we   (req_we[0]),
        .req_addr (req_addr[0]),
        .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]),
        .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]),
        .rsp_err  (rsp_err[0]),
        .busy     (busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid[1]),
        .req_we   (req_we[1]),
        .req_addr (req_addr[1]),
        .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]),
        .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]),
        .rsp_err  (rsp_err[1]),
        .busy     (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; returns rsp data/err. Scrambles req_* while busy.
    task automatic txn(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat,
                       output logic [31:0] rdata, output logic err);
        int n;
        chk("ready_before", {31'd0, req_ready[s]}, 32'd1);
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        req_we[s]    = ~we;
        req_addr[s]  = 32'hFFFF_FFF8;
        req_wdata[s] = 32'h5555_5555;
        chk("busy_after_acc", {30'd0, busy[s], req_ready[s]}, 32'd2);
        n = 0;
        while (!rsp_valid[s] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        // n counts edges after accept before the strobe is seen,
        // so the response cycle is number n+1 after the accept edge.
        chk("latency", n + 1, exp_lat + 1);
        rdata = rsp_rdata[s];
        err   = rsp_err[s];
        @(posedge clk);
        #1;
        chk("strobe_1cyc", {31'd0, rsp_valid[s]}, 32'd0);
        chk("hold_rdata", rsp_rdata[s], rdata);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset then idle for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_w2", {req_ready[0], busy[0], rsp_valid[0], 29'd0},
                32'h8000_0000);
            chk("idle_rdata", rsp_rdata[0], 32'd0);
        end
        chk("idle_w0", {req_ready[1], busy[1], rsp_valid[1], rsp_rdata[1][28:0]},
            32'h8000_0000);

        // Write then read 0x40.
        txn(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2, rd, er);
        chk("wr40_err", {31'd0, er}, 32'd0);
        chk("wr40_rdata_kept", rd, 32'd0);
        txn(0, 1'b0, 32'h40, 32'd0, 2, rd, er);
        chk("rd40_data", rd, 32'hDEAD_BEEF);
        chk("rd40_err", {31'd0, er}, 32'd0);

        // Misaligned write and read.
        txn(0, 1'b1, 32'h42, 32'h1234_5678, 2, rd, er);
        chk("wr42_err", {31'd0, er}, 32'd1);
        txn(0, 1'b0, 32'h40, 32'd0, 2, rd, er);
        chk("rd40_prior", rd, 32'hDEAD_BEEF);
        chk("rd40_prior_err", {31'd0, er}, 32'd0);
        txn(0, 1'b0, 32'h42, 32'd0, 2, rd, er);
        chk("rd42_data", rd, 32'd0);
        chk("rd42_err", {31'd0, er}, 32'd1);

        // Address wrap at 1 KiB.
        txn(0, 1'b1, 32'h400, 32'hA5A5_A5A5, 2, rd, er);
        txn(0, 1'b0, 32'h0, 32'd0, 2, rd, er);
        chk("wrap_data", rd, 32'hA5A5_A5A5);

        // Reset during WAIT of a write aborts it.
        txn(0, 1'b1, 32'h80, 32'h1111_2222, 2, rd, er);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h80;
        req_wdata[0] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("abort_in_wait", {30'd0, busy[0], req_ready[0]}, 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_idle", {29'd0, req_ready[0], busy[0], rsp_valid[0]},
            32'd4);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
        end
        txn(0, 1'b0, 32'h80, 32'd0, 2, rd, er);
        chk("abort_old_val", rd, 32'h1111_2222);

        // Zero wait states: preload, then back-to-back reads.
        txn(1, 1'b1, 32'h0, 32'h0BAD_0000, 0, rd, er);
        txn(1, 1'b1, 32'h4, 32'h0000_F00D, 0, rd, er);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 32'h0;
        @(posedge clk);
        #1;
        chk("b2b_rsp0", {31'd0, rsp_valid[1]}, 32'd1);
        chk("b2b_data0", rsp_rdata[1], 32'h0BAD_0000);
        chk("b2b_busy0", {30'd0, busy[1], req_ready[1]}, 32'd2);
        req_addr[1] = 32'h4;
        @(posedge clk);
        #1;
        chk("b2b_idle", {30'd0, req_ready[1], rsp_valid[1]}, 32'd2);
        chk("b2b_hold", rsp_rdata[1], 32'h0BAD_0000);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        chk("b2b_rsp1", {31'd0, rsp_valid[1]}, 32'd1);
        chk("b2b_data1", rsp_rdata[1], 32'h0000_F00D);
        chk("b2b_err1", {31'd0, rsp_err[1]}, 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_end", {30'd0, req_ready[1], rsp_valid[1]}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: clk drives all state, and reset is sampled only on the rising edge of clk.
REQ-002 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words in the array; it is a power of two.
REQ-003 Parameter WAIT_CYCLES, default 2, SHALL set the wait states inserted between acceptance and response; its range is 0..15.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 Port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port req_addr, input, 32 bits: byte address.
REQ-009 Port req_wdata, input, 32 bits: write data.
REQ-010 Port req_ready, output, 1 bit: the responder can accept a request.
REQ-011 Port rsp_valid, output, 1 bit: one-cycle completion strobe.
REQ-012 Port rsp_rdata, output, 32 bits: read data, meaningful when rsp_valid=1 and the request was a read.
REQ-013 Port rsp_err, output, 1 bit: misaligned-access flag, qualified by rsp_valid.
REQ-014 Port busy, output, 1 bit: a request is in flight; this is the initiator's stall source.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 busy SHALL be 1 in WAIT and RESP.
REQ-018 A request SHALL be accepted at the edge where req_valid=1 and req_ready=1; req_we, req_addr and req_wdata are latched at that edge.
REQ-019 On acceptance, the FSM SHALL move to WAIT with the counter loaded to WAIT_CYCLES-1; if WAIT_CYCLES=0 it moves directly to RESP.
REQ-020 In WAIT, the counter SHALL decrement by 1 per cycle; the FSM moves to RESP on the edge where the counter equals 0.
REQ-021 In RESP, rsp_valid SHALL be 1 for exactly one cycle; the next state is always IDLE.
REQ-022 Latency from the accept edge to the rsp_valid cycle SHALL be WAIT_CYCLES+1 cycles.
REQ-023 The word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-024 A misaligned access (latched addr[1:0] != 0) SHALL set rsp_err=1 in RESP; a misaligned write SHALL NOT modify the array, and a misaligned read SHALL return rsp_rdata=0.
REQ-025 An aligned write SHALL commit to the array at the edge that ends RESP.
REQ-026 An aligned read SHALL present the array word on rsp_rdata during RESP.
REQ-027 rsp_rdata SHALL hold its last value outside RESP; after a write response it is unchanged.
REQ-028 A read accepted after a write to the same address SHALL return the newly written data, with no bypass required because acceptance only occurs in IDLE.
REQ-029 Changes on req_* while busy=1 SHALL be ignored.
REQ-030 req_valid held high through a response SHALL be accepted again in the IDLE cycle that follows RESP, giving a request throughput of one per WAIT_CYCLES+2 cycles.

Reset
REQ-031 Reset SHALL force state=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0 and req_ready=1 on the next edge.
REQ-032 Reset asserted in WAIT or RESP SHALL abort the in-flight request: no write is committed and no rsp_valid is produced.
REQ-033 Array contents SHALL NOT be cleared by reset.

Structure
REQ-034 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the constant WORD_BYTES=4.
REQ-035 The storage SHALL be a sub-module named dmem_array: a single-port, synchronous-write, combinational-read 32-bit RAM of DEPTH_WORDS entries.
REQ-036 The FSM, counter and request latches SHALL reside in dmem_responder.

Verification
REQ-037 Reset then idle: req_ready=1, busy=0, rsp_valid=0 and rsp_rdata=0 for 5 cycles.
REQ-038 With WAIT_CYCLES=2, write 0xDEADBEEF to 0x40 and then read 0x40: rsp_valid occurs exactly 3 cycles after each accept, and the read returns 0xDEADBEEF with rsp_err=0.
REQ-039 With WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 with req_valid held high: each rsp_valid comes 1 cycle after its accept, accepts are 2 cycles apart, and the data matches preload.
REQ-040 Write 0x12345678 to 0x42 (misaligned): rsp_err=1; a subsequent read of 0x40 returns the prior value; a read of 0x42 returns 0 with rsp_err=1.
REQ-041 Wrap: with DEPTH_WORDS=256, write 0xA5A5A5A5 to 0x400 and then read 0x0: the read returns 0xA5A5A5A5.
REQ-042 Reset asserted during WAIT of a write of 0xFFFFFFFF to 0x80: no rsp_valid occurs, a subsequent read of 0x80 returns the old value, and state is IDLE one cycle after reset.
